// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the EX-stage iterative multiply/divide unit:
// function codes, bus widths and FSM state encoding.
package ex_muldiv_pkg;

   localparam int FUNCT_BUS = 6;
   localparam int DATA_BUS  = 32;

   localparam logic [FUNCT_BUS-1:0] FUNCT_MULT  = 6'h18;
   localparam logic [FUNCT_BUS-1:0] FUNCT_MULTU = 6'h19;
   localparam logic [FUNCT_BUS-1:0] FUNCT_DIV   = 6'h1A;
   localparam logic [FUNCT_BUS-1:0] FUNCT_DIVU  = 6'h1B;
   localparam logic [FUNCT_BUS-1:0] FUNCT_ADDU  = 6'h21;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   function automatic logic is_muldiv(input logic [FUNCT_BUS-1:0] f);
      return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
             (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
   endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// Pipeline-side bundle for the multiply/divide unit: issue, flush, stall
// request and the HI/LO result.
interface ex_muldiv_if #(parameter int WIDTH = 32);

   logic                                flush;
   logic                                start;
   logic [ex_muldiv_pkg::FUNCT_BUS-1:0] funct;
   logic [WIDTH-1:0]                    operand_a;
   logic [WIDTH-1:0]                    operand_b;
   logic                                busy;
   logic                                done;
   logic [WIDTH-1:0]                    hi;
   logic [WIDTH-1:0]                    lo;

   modport master (
      output flush, start, funct, operand_a, operand_b,
      input  busy, done, hi, lo
   );

   modport slave (
      input  flush, start, funct, operand_a, operand_b,
      output busy, done, hi, lo
   );

endinterface

// File: rtl/ex_muldiv_datapath.sv
// Shared shift/add-subtract datapath for shift-add multiply and restoring
// divide, with sign fix and the architectural HI/LO result registers.
module ex_muldiv_datapath #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             load_div,
   input  logic             load_signed,
   input  logic             dz_load,
   input  logic             step,
   input  logic             finish,
   input  logic             div_mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   logic [WIDTH-1:0]   op_q, op_d, acc_q, acc_d, sh_q, sh_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic               neg_q, neg_d, rneg_q, rneg_d;
   logic               sa, sb;
   logic [WIDTH-1:0]   abs_a, abs_b;
   logic [WIDTH:0]     sum, shifted, trial;
   logic [2*WIDTH-1:0] prod;

   function automatic logic [WIDTH-1:0] cond_neg(input logic n, input logic [WIDTH-1:0] v);
      return n ? (~v + 1'b1) : v;
   endfunction

   always_comb begin
      sa    = load_signed & a[WIDTH-1];
      sb    = load_signed & b[WIDTH-1];
      abs_a = cond_neg(sa, a);
      abs_b = cond_neg(sb, b);

      // acc holds the product high half (MUL) or partial remainder (DIV);
      // sh holds multiplier bits (MUL) or dividend/quotient bits (DIV).
      sum     = {1'b0, acc_q} + {1'b0, (sh_q[0] ? op_q : {WIDTH{1'b0}})};
      shifted = {acc_q, sh_q[WIDTH-1]};
      trial   = shifted - {1'b0, op_q};

      op_d   = op_q;
      acc_d  = acc_q;
      sh_d   = sh_q;
      neg_d  = neg_q;
      rneg_d = rneg_q;
      if (load) begin
         op_d   = load_div ? abs_b : abs_a;
         sh_d   = load_div ? abs_a : abs_b;
         acc_d  = '0;
         neg_d  = sa ^ sb;
         rneg_d = sa;
      end else if (step) begin
         if (div_mode) begin
            acc_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
            sh_d  = {sh_q[WIDTH-2:0], ~trial[WIDTH]};
         end else begin
            acc_d = sum[WIDTH:1];
            sh_d  = {sum[0], sh_q[WIDTH-1:1]};
         end
      end

      prod = {acc_d, sh_d};
      if (neg_q) prod = ~prod + 1'b1;

      hi_d = hi_q;
      lo_d = lo_q;
      if (dz_load) begin
         hi_d = a;
         lo_d = '1;
      end else if (finish) begin
         if (div_mode) begin
            lo_d = cond_neg(neg_q, sh_d);
            hi_d = cond_neg(rneg_q, acc_d);
         end else begin
            {hi_d, lo_d} = prod;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end

   // Iteration state needs no reset: it is always reloaded on accept.
   always_ff @(posedge clk) begin
      op_q   <= op_d;
      acc_q  <= acc_d;
      sh_q   <= sh_d;
      neg_q  <= neg_d;
      rneg_q <= rneg_d;
   end

   assign hi = hi_q;
   assign lo = lo_q;

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage iterative MULT/MULTU/DIV/DIVU unit: control FSM, stall request
// and done pulse around the shared multiply/divide datapath.
module ex_muldiv
   import ex_muldiv_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int CNT_BITS = 5
) (
   input  logic        clk,
   input  logic        rst,
   ex_muldiv_if.slave  bus
);

   state_e              state_q, state_d;
   logic [CNT_BITS-1:0] cnt_q, cnt_d;
   logic                accept, op_div, op_signed;
   logic                step, finish, dz_load;

   always_comb begin
      op_div    = (bus.funct == FUNCT_DIV) || (bus.funct == FUNCT_DIVU);
      op_signed = (bus.funct == FUNCT_DIV) || (bus.funct == FUNCT_MULT);
      accept    = (state_q == ST_IDLE) && bus.start && !bus.flush && is_muldiv(bus.funct);

      state_d = state_q;
      cnt_d   = cnt_q;
      step    = 1'b0;
      finish  = 1'b0;
      dz_load = 1'b0;
      if (bus.flush) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  cnt_d = CNT_BITS'(WIDTH - 1);
                  if (op_div && (bus.operand_b == '0)) begin
                     dz_load = 1'b1;
                     state_d = ST_DONE;
                  end else begin
                     state_d = op_div ? ST_DIV : ST_MUL;
                  end
               end
            end
            ST_MUL, ST_DIV: begin
               step = 1'b1;
               if (cnt_q == '0) begin
                  finish  = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.busy = accept || (state_q == ST_MUL) || (state_q == ST_DIV);
   assign bus.done = (state_q == ST_DONE) && !bus.flush;

   ex_muldiv_datapath #(.WIDTH(WIDTH)) u_dp (
      .clk         (clk),
      .rst         (rst),
      .load        (accept),
      .load_div    (op_div),
      .load_signed (op_signed),
      .dz_load     (dz_load),
      .step        (step),
      .finish      (finish),
      .div_mode    (state_q == ST_DIV),
      .a           (bus.operand_a),
      .b           (bus.operand_b),
      .hi          (bus.hi),
      .lo          (bus.lo)
   );

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed-vector bench for ex_muldiv: latency, stall window, results,
// divide-by-zero, flush and asynchronous reset.
module tb_ex_muldiv;
   import ex_muldiv_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_total = 0;
   int   n_bad   = 0;

   ex_muldiv_if #(.WIDTH(32)) bus ();

   ex_muldiv #(.WIDTH(32), .CNT_BITS(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Called at posedge+1; issues one op in cycle 0 and follows it to done.
   task automatic run_op(input string tag, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b,
                         input int exp_lat, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo);
      int lat;
      int nbusy;
      bus.funct     = f;
      bus.operand_a = a;
      bus.operand_b = b;
      bus.start     = 1'b1;
      #1;
      nbusy = bus.busy ? 1 : 0;
      lat   = -1;
      for (int c = 1; c <= 60 && lat < 0; c++) begin
         @(posedge clk);
         #1;
         bus.start = 1'b0;
         #1;
         if (bus.busy) nbusy++;
         if (bus.done) lat = c;
      end
      chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      chk({tag, "_busy_cycles"}, 64'(nbusy), 64'(exp_lat));
      chk({tag, "_hi"}, {32'h0, bus.hi}, {32'h0, exp_hi});
      chk({tag, "_lo"}, {32'h0, bus.lo}, {32'h0, exp_lo});
      @(posedge clk);
      #1;
      chk({tag, "_done_one_shot"}, {63'h0, bus.done}, 64'h0);
   endtask

   initial begin
      int ndone;
      bus.flush = 1'b0;
      bus.start = 1'b0;
      bus.funct = FUNCT_ADDU;
      bus.operand_a = '0;
      bus.operand_b = '0;

      #12;
      chk("reset_busy", {63'h0, bus.busy}, 64'h0);
      chk("reset_done", {63'h0, bus.done}, 64'h0);
      chk("reset_hi", {32'h0, bus.hi}, 64'h0);
      chk("reset_lo", {32'h0, bus.lo}, 64'h0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      run_op("multu_max", FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, 32'h0000_0001);
      run_op("mult_neg", FUNCT_MULT, 32'hFFFF_FFFD, 32'd7, 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run_op("div_ovf", FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0000_0000, 32'h8000_0000);
      run_op("div_neg", FUNCT_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("divu", FUNCT_DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14);
      run_op("divu_zero", FUNCT_DIVU, 32'h0000_1234, 32'h0, 1, 32'h0000_1234, 32'hFFFF_FFFF);

      // Flush a divide mid-flight.
      bus.funct = FUNCT_DIV;
      bus.operand_a = 32'd100;
      bus.operand_b = 32'd7;
      bus.start = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk);
         #1;
         bus.start = 1'b0;
         if (c == 10) bus.flush = 1'b1;
      end
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      #1;
      chk("flush_busy", {63'h0, bus.busy}, 64'h0);
      ndone = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #1;
         if (bus.done) ndone++;
      end
      chk("flush_no_done", 64'(ndone), 64'h0);
      chk("flush_hi_kept", {32'h0, bus.hi}, 64'h0000_1234);
      chk("flush_lo_kept", {32'h0, bus.lo}, 64'hFFFF_FFFF);

      // Non-muldiv function code is ignored.
      bus.funct = FUNCT_ADDU;
      bus.start = 1'b1;
      #1;
      chk("addu_busy_c0", {63'h0, bus.busy}, 64'h0);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      #1;
      chk("addu_busy_c1", {63'h0, bus.busy}, 64'h0);
      chk("addu_done_c1", {63'h0, bus.done}, 64'h0);

      // flush together with start in IDLE: not accepted.
      bus.funct = FUNCT_MULTU;
      bus.operand_a = 32'd3;
      bus.operand_b = 32'd5;
      bus.start = 1'b1;
      bus.flush = 1'b1;
      #1;
      chk("flush_start_busy_c0", {63'h0, bus.busy}, 64'h0);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.flush = 1'b0;
      #1;
      chk("flush_start_busy_c1", {63'h0, bus.busy}, 64'h0);

      // Asynchronous reset in the middle of a multiply.
      @(posedge clk);
      #1;
      bus.funct = FUNCT_MULTU;
      bus.operand_a = 32'd7;
      bus.operand_b = 32'd9;
      bus.start = 1'b1;
      for (int c = 1; c <= 15; c++) begin
         @(posedge clk);
         #1;
         bus.start = 1'b0;
      end
      #1;
      chk("pre_rst_busy", {63'h0, bus.busy}, 64'h1);
      #2;
      rst = 1'b0;
      #1;
      chk("rst_busy", {63'h0, bus.busy}, 64'h0);
      chk("rst_done", {63'h0, bus.done}, 64'h0);
      chk("rst_hi", {32'h0, bus.hi}, 64'h0);
      chk("rst_lo", {32'h0, bus.lo}, 64'h0);
      #2;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_busy", {63'h0, bus.busy}, 64'h0);
      run_op("multu_small", FUNCT_MULTU, 32'd3, 32'd5, 33, 32'd0, 32'd15);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
